serial_logic_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/serial_logic_sequencer_if.sv | 27 ++
 rtl/bit_logic_cell.sv | 35 +++
 rtl/serial_logic_sequencer.sv | 125 ++++++++++++
 tb/tb_serial_logic_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the serial logic unit.
//   - 2-bit logic op encodings (XOR, AND, OR, NOT A)
//   - sequencer FSM state type
package cpu_pkg;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_logic_sequencer_if.sv
// Control-path handshake and operand bus for the serial logic sequencer.
//   start/op/a/b : issued by the CPU (master)
//   busy/done    : handshake status from the sequencer (slave)
//   result/zero/parity : held result and flags, valid while done=1 and afterwards
interface serial_logic_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, parity
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, parity
    );
endinterface

// File: rtl/bit_logic_cell.sv
// Single-bit logic cell: y = f(op, a, b).
//   op : operation select (XOR, AND, OR, NOT A)
//   a  : operand A bit
//   b  : operand B bit (ignored for NOT A)
//   y  : result bit
module bit_logic_cell
    import cpu_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    logic y_xor;
    logic y_and;
    logic y_or;
    logic y_nota;

    xor u_xor (y_xor, a, b);
    and u_and (y_and, a, b);
    or  u_or  (y_or, a, b);
    not u_not (y_nota, a);

    always_comb begin
        y = 1'b0;
        unique case (op)
            OP_XOR:  y = y_xor;
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_NOTA: y = y_nota;
        endcase
    end

endmodule

// File: rtl/serial_logic_sequencer.sv
// Bit-serial WIDTH-bit logic unit. Runs one bit per clock through a single
// bit_logic_cell, LSB first, and returns result plus zero/parity flags.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of the start/busy/done handshake and operand/result bus
// Accept at edge E0, done high after edge E(WIDTH); one op per WIDTH+2 cycles.
module serial_logic_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_logic_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;

    logic             cell_y;
    logic [WIDTH-1:0] acc_shifted;

    bit_logic_cell u_cell (
        .op (op_q),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .y  (cell_y)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 sits at position 0.
    assign acc_shifted = {cell_y, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        par_d    = par_q;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SHIFT;
                    op_d    = bus.op;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    cnt_d   = '0;
                    acc_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                acc_d  = acc_shifted;
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                par_d  = par_q ^ cell_y;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    // Last bit: publish from the just-computed values, not the
                    // stale accumulator.
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = acc_shifted;
                    zero_d   = (acc_shifted == '0);
                    parity_d = par_q ^ cell_y;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            par_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            par_q    <= par_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.parity = parity_q;

endmodule

// File: tb/tb_serial_logic_sequencer.sv
// Directed bench for serial_logic_sequencer: table of ops with hand-computed
// results, plus held-start, back-to-back and mid-operation reset sequences.
module tb_serial_logic_sequencer;
    import cpu_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    serial_logic_sequencer_if #(.WIDTH(W)) bus ();

    serial_logic_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         par;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, scramble inputs after acceptance, check everything.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = ~v.a;
        bus.b     = ~v.b;
        bus.op    = v.op ^ 2'b11;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd16);
        check({tag, " result"}, 32'(bus.result), 32'(v.res));
        check({tag, " zero"}, 32'(bus.zero), 32'(v.zero));
        check({tag, " parity"}, 32'(bus.parity), 32'(v.par));
        tick();
        check({tag, " idle after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, c1, c2, seen;
        logic held_ok;

        vecs[0] = '{OP_XOR,  16'hA5A5, 16'h0F0F, 16'hAAAA, 1'b0, 1'b0};
        vecs[1] = '{OP_XOR,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{OP_OR,   16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[3] = '{OP_AND,  16'hFFFF, 16'h8001, 16'h8001, 1'b0, 1'b0};
        vecs[4] = '{OP_NOTA, 16'h00FF, 16'hFFFF, 16'hFF00, 1'b0, 1'b0};
        vecs[5] = '{OP_OR,   16'h8000, 16'h0006, 16'h8006, 1'b0, 1'b1};

        bus.start = 1'b0;
        bus.op    = OP_XOR;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset flags", {30'd0, bus.zero, bus.parity}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Held start: first op with inputs scrambled in flight, then a second
        // op set up at the done cycle, accepted at the first IDLE edge.
        bus.op    = OP_XOR;
        bus.a     = 16'hA5A5;
        bus.b     = 16'h0F0F;
        bus.start = 1'b1;
        tick();
        c0 = cyc;
        held_ok = 1'b1;
        n = 0;
        while (!bus.done && n < 40) begin
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            bus.op = 2'($urandom);
            if (bus.result !== 16'h8006) held_ok = 1'b0;
            tick();
            n++;
        end
        c1 = cyc;
        check("hold first latency", 32'(c1 - c0), 32'd16);
        check("hold result before first done", 32'(held_ok), 32'd1);
        check("hold first result", 32'(bus.result), 32'hAAAA);
        bus.op = OP_AND;
        bus.a  = 16'hFFFF;
        bus.b  = 16'h8001;
        held_ok = 1'b1;
        tick();
        n = 0;
        while (!bus.done && n < 40) begin
            if (bus.result !== 16'hAAAA) held_ok = 1'b0;
            tick();
            n++;
        end
        c2 = cyc;
        bus.start = 1'b0;
        check("b2b done spacing", 32'(c2 - c1), 32'd18);
        check("b2b result held", 32'(held_ok), 32'd1);
        check("b2b second result", 32'(bus.result), 32'h8001);
        check("b2b second parity", 32'(bus.parity), 32'd0);
        tick();
        check("b2b idle", 32'(bus.busy), 32'd0);

        // Reset 5 edges after acceptance aborts the op.
        bus.op    = OP_XOR;
        bus.a     = 16'hA5A5;
        bus.b     = 16'h0F0F;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort result", 32'(bus.result), 32'd0);
        check("abort flags", {30'd0, bus.zero, bus.parity}, 32'd0);
        seen = 0;
        repeat (20) begin
            if (bus.done) seen++;
            tick();
        end
        check("abort no done", 32'(seen), 32'd0);
        run_vec(vecs[0], "after abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
